dijkstra_relax_step: RTL and testbench

Nios II extended custom instruction that performs a full Dijkstra edge relaxation in hardware. It holds a base distance (dist[u]), adds an edge weight through the `fp_add` IEEE-754 single-precision pipeline, compares the sum with dist[v] and returns the minimum. It also keeps saturating relaxation and update counters for profiling. It sits on the CPU custom-instruction port as a multicycle, start/done instruction.

---
 rtl/dijkstra_relax_step_if.sv | 18 +
 rtl/dijkstra_relax_step.sv | 219 +++++++++++++++++++++
 tb/tb_dijkstra_relax_step.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dijkstra_relax_step_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dijkstra_relax_step_if : custom-instruction port between CPU and relax unit |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface dijkstra_relax_step_if;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done;
    logic [31:0] result;

    modport master (output clk_en, start, n, dataa, datab, input done, result);
    modport slave  (input clk_en, start, n, dataa, datab, output done, result);
endinterface
`default_nettype wire

// File: rtl/dijkstra_relax_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dijkstra_relax_step : multicycle custom instruction, dist = min(base+w, dv) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dijkstra_relax_step #(
    parameter int ADD_LATENCY = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dijkstra_relax_step_if.slave ci
);
    localparam logic [31:0] c_INF = 32'h7F800000;
    localparam int          WAIT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;
    localparam logic [WAIT_W-1:0]    c_WAIT_LAST = WAIT_W'(ADD_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX   = '1;
    localparam logic [1:0] c_OP_SET_BASE = 2'd0;
    localparam logic [1:0] c_OP_RELAX    = 2'd1;
    localparam logic [1:0] c_OP_READ     = 2'd2;
    localparam logic [1:0] c_OP_CLEAR    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ADD_WAIT = 2'd1,
        S_CMP      = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t               state_q;
    logic [31:0]          base_q;
    logic [31:0]          w_q;
    logic [31:0]          dv_q;
    logic [31:0]          cand_q;
    logic [31:0]          result_q;
    logic                 done_q;
    logic [1:0]           op_q;
    logic [WAIT_W-1:0]    wait_q;
    logic [CNT_WIDTH-1:0] relax_cnt_q;
    logic [CNT_WIDTH-1:0] relax_cnt_d;
    logic [CNT_WIDTH-1:0] upd_cnt_q;
    logic [CNT_WIDTH-1:0] upd_cnt_d;

    // fp_add datapath: operands are non-negative, so this is a pure magnitude add
    logic [31:0] add_b;
    logic        add_unused_sign;
    logic [30:0] add_x;
    logic [30:0] add_y;
    logic [7:0]  add_ex;
    logic [7:0]  add_ey;
    logic [7:0]  add_d;
    logic [23:0] add_mx;
    logic [23:0] add_my;
    logic [26:0] add_ext;
    logic [26:0] add_shf;
    logic [26:0] add_mask;
    logic [26:0] add_al;
    logic [27:0] add_sum;
    logic [26:0] add_m;
    logic [8:0]  add_e;
    logic        add_rnd;
    logic [24:0] add_mant;
    logic [31:0] add_res;
    logic [31:0] add_pipe_q [ADD_LATENCY];

    // The weight enters the adder straight from dataa in the start cycle so the
    // pipeline output lines up with the last ADD_WAIT cycle.
    assign add_b           = (state_q == S_IDLE) ? ci.dataa : w_q;
    assign add_unused_sign = add_b[31];

    always_comb begin
        add_x = base_q[30:0];
        add_y = add_b[30:0];
        if (add_b[30:0] > base_q[30:0]) begin
            add_x = add_b[30:0];
            add_y = base_q[30:0];
        end
        add_ex   = (add_x[30:23] == 8'd0) ? 8'd1 : add_x[30:23];
        add_ey   = (add_y[30:23] == 8'd0) ? 8'd1 : add_y[30:23];
        add_mx   = {(add_x[30:23] != 8'd0), add_x[22:0]};
        add_my   = {(add_y[30:23] != 8'd0), add_y[22:0]};
        add_d    = add_ex - add_ey;
        add_ext  = {add_my, 3'b000};
        add_shf  = add_ext >> add_d;
        add_mask = (27'd1 << add_d) - 27'd1;
        add_al   = {add_shf[26:1], add_shf[0] | (|(add_ext & add_mask))};
        if (add_d >= 8'd27) begin
            add_al = {26'd0, |add_my};
        end
        add_sum = {1'b0, add_mx, 3'b000} + {1'b0, add_al};
        add_e   = {1'b0, add_ex};
        add_m   = add_sum[26:0];
        if (add_sum[27]) begin
            add_m = {add_sum[27:2], add_sum[1] | add_sum[0]};
            add_e = add_e + 9'd1;
        end
        // round to nearest, ties to even, on guard/round/sticky
        add_rnd  = add_m[2] & (add_m[1] | add_m[0] | add_m[3]);
        add_mant = {1'b0, add_m[26:3]} + {24'd0, add_rnd};
        if (add_mant[24]) begin
            add_mant = add_mant >> 1;
            add_e    = add_e + 9'd1;
        end
        if (!add_mant[23]) begin
            add_e = 9'd0;
        end
        add_res = {1'b0, add_e[7:0], add_mant[22:0]};
        if (add_e >= 9'd255) begin
            add_res = c_INF;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ADD_LATENCY; i++) begin
                add_pipe_q[i] <= '0;
            end
        end else if (ci.clk_en) begin
            add_pipe_q[0] <= add_res;
            for (int i = 1; i < ADD_LATENCY; i++) begin
                add_pipe_q[i] <= add_pipe_q[i-1];
            end
        end
    end

    assign relax_cnt_d = (relax_cnt_q == c_CNT_MAX) ? relax_cnt_q : relax_cnt_q + CNT_WIDTH'(1);
    assign upd_cnt_d   = (upd_cnt_q == c_CNT_MAX) ? upd_cnt_q : upd_cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            base_q      <= c_INF;
            w_q         <= '0;
            dv_q        <= '0;
            cand_q      <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            op_q        <= c_OP_SET_BASE;
            wait_q      <= '0;
            relax_cnt_q <= '0;
            upd_cnt_q   <= '0;
        end else if (ci.clk_en) begin
            case (state_q)
                S_IDLE: begin
                    done_q   <= 1'b0;
                    result_q <= '0;
                    if (ci.start) begin
                        w_q  <= ci.dataa;
                        dv_q <= ci.datab;
                        op_q <= ci.n;
                        case (ci.n)
                            c_OP_RELAX: begin
                                wait_q <= '0;
                                if ((base_q == c_INF) || (ci.dataa == c_INF)) begin
                                    cand_q  <= c_INF;
                                    state_q <= S_CMP;
                                end else begin
                                    state_q <= S_ADD_WAIT;
                                end
                            end
                            c_OP_READ: begin
                                done_q   <= 1'b1;
                                result_q <= {16'(upd_cnt_q), 16'(relax_cnt_q)};
                                state_q  <= S_DONE;
                            end
                            c_OP_CLEAR: begin
                                done_q   <= 1'b1;
                                result_q <= '0;
                                state_q  <= S_DONE;
                            end
                            default: begin
                                done_q   <= 1'b1;
                                result_q <= ci.dataa;
                                state_q  <= S_DONE;
                            end
                        endcase
                    end
                end
                S_ADD_WAIT: begin
                    if (wait_q == c_WAIT_LAST) begin
                        cand_q  <= add_pipe_q[ADD_LATENCY-1];
                        state_q <= S_CMP;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_CMP: begin
                    // unsigned compare orders non-negative floats and +inf correctly
                    relax_cnt_q <= relax_cnt_d;
                    if (cand_q < dv_q) begin
                        result_q  <= cand_q;
                        upd_cnt_q <= upd_cnt_d;
                    end else begin
                        result_q <= dv_q;
                    end
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    if (op_q == c_OP_SET_BASE) begin
                        base_q <= w_q;
                    end
                    if (op_q == c_OP_CLEAR) begin
                        relax_cnt_q <= '0;
                        upd_cnt_q   <= '0;
                    end
                    done_q   <= 1'b0;
                    result_q <= '0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign ci.done   = done_q;
    assign ci.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_dijkstra_relax_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dijkstra_relax_step : two instances (16-bit and 2-bit counters) in step  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dijkstra_relax_step;
    localparam int          c_LAT = 2;
    localparam logic [31:0] c_INF = 32'h7F800000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dijkstra_relax_step_if ci16();
    dijkstra_relax_step_if ci2();

    dijkstra_relax_step #(.ADD_LATENCY(c_LAT), .CNT_WIDTH(16)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .ci(ci16.slave));
    dijkstra_relax_step #(.ADD_LATENCY(c_LAT), .CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .ci(ci2.slave));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_base;
    int          m_relax;
    int          m_upd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        ci16.start = st; ci16.n = op; ci16.dataa = a; ci16.datab = b;
        ci2.start  = st; ci2.n  = op; ci2.dataa  = a; ci2.datab  = b;
    endtask

    task automatic set_en(input logic en);
        ci16.clk_en = en;
        ci2.clk_en  = en;
    endtask

    // Exact sum of two non-negative singles, then round-to-nearest-even
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [127:0] s, ma, mb, keep, rem, half;
        int ea, eb, emin, p, sh, e;
        if (a[30:0] == 31'd0) return b;
        if (b[30:0] == 31'd0) return a;
        ea   = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
        eb   = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
        ma   = 128'({(a[30:23] != 8'd0), a[22:0]});
        mb   = 128'({(b[30:23] != 8'd0), b[22:0]});
        emin = (ea < eb) ? ea : eb;
        s    = (ma << (ea - emin)) + (mb << (eb - emin));
        p    = 127;
        while (!s[p]) p--;
        e = emin + p - 23;
        if (e < 1) return {9'd0, s[22:0]};
        if (p <= 23) begin
            keep = s << (23 - p);
        end else begin
            sh   = p - 23;
            keep = s >> sh;
            rem  = s & ((128'd1 << sh) - 128'd1);
            half = 128'd1 << (sh - 1);
            if ((rem > half) || ((rem == half) && keep[0])) keep = keep + 128'd1;
            if (keep[24]) begin
                keep = keep >> 1;
                e++;
            end
        end
        if (e >= 255) return c_INF;
        return {1'b0, e[7:0], keep[22:0]};
    endfunction

    function automatic logic [31:0] ref_cand(input logic [31:0] w);
        if ((m_base == c_INF) || (w == c_INF)) return c_INF;
        return ref_add(m_base, w);
    endfunction

    function automatic logic [31:0] stat_word(input int w);
        int lim, u, r;
        lim = (1 << w) - 1;
        u = (m_upd > lim) ? lim : m_upd;
        r = (m_relax > lim) ? lim : m_relax;
        return {16'(u), 16'(r)};
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [7:0] e;
        e = 8'($urandom_range(150, 100));
        return {1'b0, e, 23'($urandom)};
    endfunction

    task automatic model_reset();
        m_base = c_INF; m_relax = 0; m_upd = 0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int stall_at, input int stall_len, input int hold_len);
        logic [31:0] exp16, exp2, cand;
        int          exp_lat, c;
        exp_lat = 1;
        case (op)
            2'd0: begin exp16 = a; exp2 = a; m_base = a; end
            2'd1: begin
                cand    = ref_cand(a);
                exp_lat = ((m_base == c_INF) || (a == c_INF)) ? 2 : c_LAT + 2;
                exp16   = (cand < b) ? cand : b;
                exp2    = exp16;
                m_relax++;
                if (cand < b) m_upd++;
            end
            2'd2: begin exp16 = stat_word(16); exp2 = stat_word(2); end
            default: begin exp16 = '0; exp2 = '0; m_relax = 0; m_upd = 0; end
        endcase
        exp_lat += stall_len;

        @(negedge clk);
        set_en(1'b1);
        drive(1'b1, op, a, b);
        @(negedge clk);
        drive(1'b0, 2'($urandom), $urandom, $urandom);
        c = 1;
        while (c <= 40) begin
            if (c == stall_at) set_en(1'b0);
            if (c == stall_at + stall_len) set_en(1'b1);
            if (ci16.done === 1'b1) break;
            @(negedge clk);
            c++;
        end
        chk({tag, "_lat"}, 32'(c), 32'(exp_lat));
        chk({tag, "_done2"}, {31'd0, ci2.done}, 32'd1);
        chk({tag, "_res16"}, ci16.result, exp16);
        chk({tag, "_res2"}, ci2.result, exp2);
        if (hold_len > 0) begin
            set_en(1'b0);
            repeat (hold_len) @(negedge clk);
            chk({tag, "_hold_done"}, {31'd0, ci16.done}, 32'd1);
            chk({tag, "_hold_res"}, ci16.result, exp16);
            set_en(1'b1);
        end
        @(negedge clk);
        chk({tag, "_drop"}, {30'd0, ci16.done, ci2.done}, 32'd0);
        chk({tag, "_drop_res"}, ci16.result | ci2.result, 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] w, dv, cand;
        int          r;
        set_en(1'b1);
        drive(1'b0, 2'd0, 32'd0, 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_done", {30'd0, ci16.done, ci2.done}, 32'd0);
        chk("rst_res", ci16.result | ci2.result, 32'd0);
        reset_n = 1'b1;

        run_op("rd0", 2'd2, 32'h0, 32'h0, 0, 0, 0);
        run_op("setb", 2'd0, 32'h3F800000, 32'h0, 0, 0, 2);
        run_op("upd", 2'd1, 32'h40000000, 32'h40A00000, 0, 0, 0);
        run_op("rd1", 2'd2, 32'h0, 32'h0, 0, 0, 0);
        run_op("noupd", 2'd1, 32'h40000000, 32'h40000000, 0, 0, 0);
        run_op("tie", 2'd1, 32'h40000000, 32'h40400000, 0, 0, 0);
        run_op("rd2", 2'd2, 32'h0, 32'h0, 0, 0, 0);
        run_op("winf", 2'd1, c_INF, 32'h41200000, 0, 0, 0);
        run_op("stall", 2'd1, 32'h40000000, 32'h40A00000, 2, 3, 0);

        for (int i = 0; i < 5; i++) run_op("sat", 2'd1, 32'h40000000, 32'h40A00000, 0, 0, 0);
        run_op("rdsat", 2'd2, 32'h0, 32'h0, 0, 0, 0);
        run_op("clr", 2'd3, 32'h0, 32'h0, 0, 0, 0);
        run_op("rdclr", 2'd2, 32'h0, 32'h0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(9);
            if (r == 0) begin
                run_op("r_set", 2'd0, ($urandom_range(7) == 0) ? c_INF : rnd_f(), 32'h0, 0, 0, 0);
            end else if (r == 1) begin
                run_op("r_read", 2'd2, $urandom, $urandom, 0, 0, 0);
            end else if (r == 2 && $urandom_range(3) == 0) begin
                run_op("r_clr", 2'd3, $urandom, $urandom, 0, 0, 0);
            end else begin
                w    = ($urandom_range(9) == 0) ? c_INF : rnd_f();
                cand = ref_cand(w);
                case ($urandom_range(3))
                    0: dv = rnd_f();
                    1: dv = cand;
                    2: dv = (cand == c_INF) ? cand : cand + 32'd1;
                    default: dv = (cand == c_INF) ? rnd_f() : cand - 32'd1;
                endcase
                run_op("r_relax", 2'd1, w, dv, 0, 0, 0);
            end
        end

        // reset in cycle 2 of a RELAX aborts it without a done pulse
        run_op("setb2", 2'd0, 32'h3F800000, 32'h0, 0, 0, 0);
        @(negedge clk);
        drive(1'b1, 2'd1, 32'h40000000, 32'h40A00000);
        @(negedge clk);
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rstmid_done", {30'd0, ci16.done, ci2.done}, 32'd0);
        chk("rstmid_res", ci16.result | ci2.result, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rstmid_nodone", {30'd0, ci16.done, ci2.done}, 32'd0);
        end
        run_op("rdrst", 2'd2, 32'h0, 32'h0, 0, 0, 0);
        run_op("binf", 2'd1, 32'h40000000, 32'h41200000, 0, 0, 0);

        // reset while done is high drops it at once
        @(negedge clk);
        drive(1'b1, 2'd2, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        chk("rstdone_pre", {31'd0, ci16.done}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstdone_done", {30'd0, ci16.done, ci2.done}, 32'd0);
        chk("rstdone_res", ci16.result | ci2.result, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        run_op("rdend", 2'd2, 32'h0, 32'h0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
